cook_sequencer: RTL and testbench
=================================

Name: cook_sequencer

Overview:
Top-level cook controller for the microwave. It sequences the turntable motor controller through its run input and gates magnetron heating with a power-level duty pattern. It counts cook time down in seconds, handles pause, resume and cancel from debounced front-panel pulses and the door switch, and drives the done buzzer.

Parameters:
SLOT_CYC, 10_000_000, clk cycles per heat slot; one second is 10 slots (100 MHz clk). Benches override it small.
MAX_SEC, 5999, saturation limit of remaining time (99:59).
ADD_SEC, 30, seconds added per btn_add pulse.
BEEP_SEC, 3, buzzer duration in DONE, in seconds.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_start  in  1  one-cycle pulse, start/resume
btn_stop  in  1  one-cycle pulse, pause/cancel
btn_add  in  1  one-cycle pulse, add ADD_SEC
door_open  in  1  level, 1 = door open
power_lvl  in  4  heat slots per second, 0..10; values >10 are treated as 10
motor_run  out  1  to motor controller run
heat_on  out  1  magnetron enable
buzzer  out  1  done beeper
done_pulse  out  1  one-cycle pulse on entry to DONE
remain_sec  out  13  remaining seconds
state_o  out  3  IDLE=0, COOK=1, PAUSE=2, DONE=3

Behaviour:
- Reset (sync, rst high at clk edge): state IDLE, remain_sec 0, all counters 0, latched power 0, all outputs 0. Reset overrides every other input, including mid-COOK.
- All outputs are registered. Each output reflects the state and counters in the same cycle as the state register.
- Timebase: slot_cnt counts 0..SLOT_CYC-1 and slot_idx counts 0..9. sec_tick = (slot_idx==9 && slot_cnt==SLOT_CYC-1).
  - Timebase runs only in COOK and DONE.
  - Timebase clears to 0 on every state change and whenever it is not running. A partial second is discarded on pause.
- btn_add: remain_sec = min(remain_sec + ADD_SEC, MAX_SEC) in IDLE, COOK and PAUSE.
  - In DONE, btn_add moves to IDLE with remain_sec = ADD_SEC.
- IDLE:
  - btn_stop clears remain_sec to 0.
  - btn_start && !door_open && remain_sec>0 moves to COOK and latches clamped power_lvl.
  - btn_start with remain_sec==0 or door open is ignored.
- COOK:
  - motor_run=1. heat_on = (slot_idx < latched power).
  - Priority: btn_stop or door_open moves to PAUSE; remain unchanged, no decrement that cycle.
  - Otherwise on sec_tick:
    - with btn_add: remain = min(remain-1+ADD_SEC, MAX_SEC), stay in COOK.
    - else if remain==1: remain=0, go to DONE, done_pulse=1 on the entry cycle.
    - else: remain-1.
  - btn_start in COOK is ignored.
- PAUSE:
  - motor_run=0, heat_on=0.
  - btn_stop moves to IDLE, remain=0. Stop beats start.
  - btn_start && !door_open moves to COOK and re-latches power_lvl.
  - btn_start with door open is ignored.
- DONE:
  - buzzer=1, motor_run=0, heat_on=0, remain_sec=0.
  - After BEEP_SEC sec_ticks, go to IDLE.
  - btn_stop or door_open goes to IDLE immediately.
  - btn_start is ignored.
- Simultaneous button pulses: stop > start. btn_add is applied alongside any non-cancelling transition.
- remain_sec never wraps below 0 and never exceeds MAX_SEC.

Test Plan (SLOT_CYC=2, so one second = 20 clk; ADD_SEC=30, BEEP_SEC=3, MAX_SEC=5999):
- Basic cook: rst, then btn_add, then btn_start with power_lvl=4.
  - state=COOK and motor_run=1 one cycle after start.
  - heat_on high for 8 of every 20 clk.
  - remain_sec reaches 0 after 600 clk; done_pulse fires once; buzzer high for 60 clk, then IDLE.
- Door during cook: at remain=25, raise door_open.
  - Next cycle: PAUSE, motor_run=0, heat_on=0, remain stays 25.
  - btn_start while the door is open is ignored.
  - Close the door and pulse btn_start: COOK; the next decrement occurs exactly 20 clk later.
- Cancel: in PAUSE, pulse btn_start and btn_stop in the same cycle → IDLE, remain_sec=0.
- Saturation/collision:
  - 200 btn_add pulses give remain_sec=5999.
  - In COOK with remain=1, btn_add coincident with sec_tick gives remain=30, state stays COOK, no done_pulse.
- Power bounds:
  - power_lvl=0: heat_on never asserts while motor_run=1.
  - power_lvl=15: heat_on stays high throughout COOK.
  - Changing power_lvl mid-COOK has no effect until the next resume.
- Reset mid-operation: assert rst in COOK with remain=17 → next cycle all outputs 0 and state_o=0; btn_start ignored until btn_add.

Source files
------------

// File: rtl/cook_sequencer.sv
// rtl/cook_sequencer.sv - microwave cook controller: timebase, power duty gating, countdown, pause/cancel, done buzzer
module cook_sequencer #(
   parameter int SLOT_CYC = 10_000_000,
   parameter int MAX_SEC  = 5999,
   parameter int ADD_SEC  = 30,
   parameter int BEEP_SEC = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_start,
   input  logic        btn_stop,
   input  logic        btn_add,
   input  logic        door_open,
   input  logic [3:0]  power_lvl,
   output logic        motor_run,
   output logic        heat_on,
   output logic        buzzer,
   output logic        done_pulse,
   output logic [12:0] remain_sec,
   output logic [2:0]  state_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COOK  = 3'd1,
      PAUSE = 3'd2,
      DONE  = 3'd3
   } state_t;

   localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
   localparam int BW = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;

   state_t        state, nxt_state;
   logic [CW-1:0] slot_cnt, nxt_slot_cnt;
   logic [3:0]    slot_idx, nxt_slot_idx;
   logic [BW-1:0] beep_cnt, nxt_beep_cnt;
   logic [3:0]    power, nxt_power, power_clamped;
   logic [12:0]   remain, nxt_remain, remain_add, tick_add;
   logic          sec_tick, running;

   function automatic logic [12:0] sat_max(input logic [13:0] sum);
      return (sum > 14'(MAX_SEC)) ? 13'(MAX_SEC) : sum[12:0];
   endfunction

   assign power_clamped = (power_lvl > 4'd10) ? 4'd10 : power_lvl;
   assign remain_add    = sat_max({1'b0, remain} + 14'(ADD_SEC));
   assign tick_add      = sat_max({1'b0, remain} + 14'(ADD_SEC) - 14'd1);
   assign sec_tick      = (slot_idx == 4'd9) && (slot_cnt == CW'(SLOT_CYC - 1));

   always_comb begin
      nxt_state    = state;
      nxt_remain   = remain;
      nxt_power    = power;
      nxt_beep_cnt = beep_cnt;
      nxt_slot_cnt = '0;
      nxt_slot_idx = 4'd0;
      running      = 1'b0;
      case (state)
         IDLE: begin
            if (btn_stop) begin
               nxt_remain = 13'd0;
            end else begin
               if (btn_add) nxt_remain = remain_add;
               if (btn_start && !door_open && remain != 13'd0) begin
                  nxt_state = COOK;
                  nxt_power = power_clamped;
               end
            end
         end
         COOK: begin
            // pausing freezes remain; the partial second is dropped with the timebase
            if (btn_stop || door_open) begin
               nxt_state = PAUSE;
            end else if (sec_tick) begin
               if (btn_add) begin
                  nxt_remain = tick_add;
               end else if (remain <= 13'd1) begin
                  nxt_remain = 13'd0;
                  nxt_state  = DONE;
               end else begin
                  nxt_remain = remain - 13'd1;
               end
            end else if (btn_add) begin
               nxt_remain = remain_add;
            end
         end
         PAUSE: begin
            if (btn_stop) begin
               nxt_state  = IDLE;
               nxt_remain = 13'd0;
            end else begin
               if (btn_add) nxt_remain = remain_add;
               if (btn_start && !door_open) begin
                  nxt_state = COOK;
                  nxt_power = power_clamped;
               end
            end
         end
         DONE: begin
            if (btn_stop || door_open) begin
               nxt_state  = IDLE;
               nxt_remain = 13'd0;
            end else if (btn_add) begin
               nxt_state  = IDLE;
               nxt_remain = 13'(ADD_SEC);
            end else if (sec_tick) begin
               if (beep_cnt == BW'(BEEP_SEC - 1)) nxt_state = IDLE;
               else nxt_beep_cnt = beep_cnt + 1'b1;
            end
         end
         default: begin
            nxt_state  = IDLE;
            nxt_remain = 13'd0;
         end
      endcase

      running = (nxt_state == COOK) || (nxt_state == DONE);
      if (running && nxt_state == state) begin
         if (slot_cnt == CW'(SLOT_CYC - 1)) begin
            nxt_slot_idx = (slot_idx == 4'd9) ? 4'd0 : slot_idx + 4'd1;
         end else begin
            nxt_slot_cnt = slot_cnt + 1'b1;
            nxt_slot_idx = slot_idx;
         end
      end
      if (nxt_state != DONE || state != DONE) nxt_beep_cnt = '0;
   end

   // outputs are derived from next-state values so they align with the state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         remain     <= 13'd0;
         power      <= 4'd0;
         slot_cnt   <= '0;
         slot_idx   <= 4'd0;
         beep_cnt   <= '0;
         motor_run  <= 1'b0;
         heat_on    <= 1'b0;
         buzzer     <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         state      <= nxt_state;
         remain     <= nxt_remain;
         power      <= nxt_power;
         slot_cnt   <= nxt_slot_cnt;
         slot_idx   <= nxt_slot_idx;
         beep_cnt   <= nxt_beep_cnt;
         motor_run  <= (nxt_state == COOK);
         heat_on    <= (nxt_state == COOK) && (nxt_slot_idx < nxt_power);
         buzzer     <= (nxt_state == DONE);
         done_pulse <= (nxt_state == DONE) && (state != DONE);
      end
   end

   assign remain_sec = remain;
   assign state_o    = state;

endmodule

// File: tb/tb_cook_sequencer.sv
// tb/tb_cook_sequencer.sv - directed self-checking bench for cook_sequencer
module tb_cook_sequencer;

   logic        clk = 1'b0;
   logic        rst, btn_start, btn_stop, btn_add, door_open;
   logic [3:0]  power_lvl;
   logic        motor_run, heat_on, buzzer, done_pulse;
   logic [12:0] remain_sec;
   logic [2:0]  state_o;
   int          errors = 0;
   int          checks = 0;
   int          heat_cnt;

   cook_sequencer #(.SLOT_CYC(2), .MAX_SEC(5999), .ADD_SEC(30), .BEEP_SEC(3)) dut (
      .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop), .btn_add(btn_add),
      .door_open(door_open), .power_lvl(power_lvl), .motor_run(motor_run), .heat_on(heat_on),
      .buzzer(buzzer), .done_pulse(done_pulse), .remain_sec(remain_sec), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic p_add();   btn_add = 1'b1;   step(); btn_add = 1'b0;   endtask
   task automatic p_start(); btn_start = 1'b1; step(); btn_start = 1'b0; endtask
   task automatic p_stop();  btn_stop = 1'b1;  step(); btn_stop = 1'b0;  endtask

   task automatic count_heat(input int n);
      heat_cnt = 0;
      for (int i = 0; i < n; i++) begin
         heat_cnt += int'(heat_on);
         step();
      end
   endtask

   initial begin
      rst = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; btn_add = 1'b0;
      door_open = 1'b0; power_lvl = 4'd4;
      run(2);
      chk("rst_state", state_o, 0);
      chk("rst_remain", remain_sec, 0);
      chk("rst_outs", {motor_run, heat_on, buzzer, done_pulse}, 0);
      rst = 1'b0;
      p_start();
      chk("idle_start_zero", state_o, 0);

      // basic cook at power 4
      p_add();
      chk("add_30", remain_sec, 30);
      p_start();
      chk("cook_state", state_o, 1);
      chk("cook_motor", motor_run, 1);
      chk("cook_heat0", heat_on, 1);
      heat_cnt = 0;
      for (int i = 0; i < 19; i++) begin
         heat_cnt += int'(heat_on);
         step();
      end
      chk("remain_c19", remain_sec, 30);
      heat_cnt += int'(heat_on);
      step();
      chk("heat_duty4", heat_cnt, 8);
      chk("remain_c20", remain_sec, 29);
      run(579);
      chk("c599_state", state_o, 1);
      chk("c599_remain", remain_sec, 1);
      chk("c599_done", done_pulse, 0);
      step();
      chk("done_state", state_o, 3);
      chk("done_remain", remain_sec, 0);
      chk("done_pulse", done_pulse, 1);
      chk("done_buzz", buzzer, 1);
      chk("done_motor_heat", {motor_run, heat_on}, 0);
      step();
      chk("done_pulse_once", done_pulse, 0);
      run(58);
      chk("beep_last_state", state_o, 3);
      chk("beep_last_buzz", buzzer, 1);
      step();
      chk("beep_end_state", state_o, 0);
      chk("beep_end_buzz", buzzer, 0);

      // door opened during cook
      p_add();
      p_start();
      run(100);
      chk("door_pre_remain", remain_sec, 25);
      door_open = 1'b1;
      step();
      chk("door_pause", state_o, 2);
      chk("door_outs", {motor_run, heat_on}, 0);
      chk("door_remain", remain_sec, 25);
      p_start();
      chk("door_start_ign", state_o, 2);
      door_open = 1'b0;
      step();
      p_start();
      chk("resume_state", state_o, 1);
      run(19);
      chk("resume_c19", remain_sec, 25);
      step();
      chk("resume_c20", remain_sec, 24);

      // cancel: stop beats start in PAUSE
      p_stop();
      chk("stop_pause", state_o, 2);
      chk("stop_remain", remain_sec, 24);
      btn_start = 1'b1; btn_stop = 1'b1;
      step();
      btn_start = 1'b0; btn_stop = 1'b0;
      chk("cancel_state", state_o, 0);
      chk("cancel_remain", remain_sec, 0);

      // saturation
      btn_add = 1'b1;
      run(199);
      chk("sat_199", remain_sec, 5970);
      step();
      chk("sat_200", remain_sec, 5999);
      step();
      chk("sat_201", remain_sec, 5999);
      btn_add = 1'b0;

      // add coincident with final sec_tick
      p_stop();
      chk("idle_stop_clear", remain_sec, 0);
      p_add();
      p_start();
      run(599);
      chk("coll_pre", remain_sec, 1);
      btn_add = 1'b1;
      step();
      btn_add = 1'b0;
      chk("coll_remain", remain_sec, 30);
      chk("coll_state", state_o, 1);
      chk("coll_done", done_pulse, 0);

      // power bounds and latching
      p_stop();
      p_stop();
      chk("pw_idle", state_o, 0);
      power_lvl = 4'd0;
      p_add();
      p_start();
      chk("pw0_motor", motor_run, 1);
      count_heat(40);
      chk("pw0_heat", heat_cnt, 0);
      power_lvl = 4'd15;
      count_heat(20);
      chk("pw_mid_change", heat_cnt, 0);
      p_stop();
      p_start();
      count_heat(40);
      chk("pw15_heat", heat_cnt, 40);
      power_lvl = 4'd0;
      count_heat(20);
      chk("pw15_hold", heat_cnt, 20);

      // reset mid-COOK
      p_stop();
      p_stop();
      p_add();
      p_start();
      run(260);
      chk("rstm_pre", remain_sec, 17);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstm_state", state_o, 0);
      chk("rstm_remain", remain_sec, 0);
      chk("rstm_outs", {motor_run, heat_on, buzzer, done_pulse}, 0);
      p_start();
      chk("rstm_start_ign", state_o, 0);
      p_add();
      p_start();
      chk("rstm_restart", state_o, 1);

      // add in DONE returns to IDLE with ADD_SEC
      run(600);
      chk("done2_state", state_o, 3);
      p_add();
      chk("done_add_state", state_o, 0);
      chk("done_add_remain", remain_sec, 30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
